// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM responder: word-organised single-port RAM with byte/halfword/word
// access, programmable wait states and the two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int unsigned mem_depth = 1024,
  parameter int unsigned wait_st   = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  output logic [31:0] hrdata,
  input  logic [31:0] hwdata,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  output logic [1:0]  hresp,
  output logic        hready,
  input  logic        hsel
);

  localparam int unsigned IDX_W = $clog2(mem_depth);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   a_idx;
  logic               a_write;
  logic [3:0]         a_lanes;

  logic               accept_c, legal_c, wr_c, ld_c;
  logic [IDX_W-1:0]   idx_c, ld_idx_c;
  logic [3:0]         lanes_c;
  logic [31:0]        rd_word_c;
  logic [31:0]        mem [mem_depth];

  // Burst type and the SEQ/NONSEQ distinction carry no meaning for this slave
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  assign accept_c = hsel & htrans[1] & hready;
  assign idx_c    = haddr[IDX_W+1:2];
  assign wr_c     = (state == DATA) && a_write;

  // Legality and byte-lane decode of the address phase
  always_comb begin
    legal_c = 1'b1;
    lanes_c = 4'b1111;
    case (hsize)
      3'd0: lanes_c = 4'b0001 << haddr[1:0];
      3'd1: begin
        lanes_c = haddr[1] ? 4'b1100 : 4'b0011;
        if (haddr[0]) legal_c = 1'b0;
      end
      3'd2: if (haddr[1:0] != 2'b00) legal_c = 1'b0;
      default: legal_c = 1'b0;
    endcase
    if (|haddr[31:IDX_W+2]) legal_c = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_c      = 1'b0;
    ld_idx_c  = a_idx;
    case (state)
      IDLE, DATA, ERR2: begin
        state_nxt = IDLE;
        if (accept_c) begin
          if (!legal_c) begin
            state_nxt = ERR1;
          end else if (wait_st != 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(wait_st - 1);
          end else begin
            state_nxt = DATA;
            ld_c      = ~hwrite;
            ld_idx_c  = idx_c;
          end
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = DATA;
          ld_c      = ~a_write;
        end
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // Read word with forwarding of a write completing on the same edge
  always_comb begin
    rd_word_c = mem[ld_idx_c];
    if (wr_c && (a_idx == ld_idx_c)) begin
      for (int i = 0; i < 4; i++) begin
        if (a_lanes[i]) rd_word_c[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state   <= IDLE;
      cnt     <= '0;
      hready  <= 1'b1;
      hresp   <= 2'd0;
      hrdata  <= '0;
      a_idx   <= '0;
      a_write <= 1'b0;
      a_lanes <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hready <= !((state_nxt == WAIT) || (state_nxt == ERR1));
      hresp  <= ((state_nxt == ERR1) || (state_nxt == ERR2)) ? 2'd1 : 2'd0;
      if (ld_c) hrdata <= rd_word_c;
      if (accept_c) begin
        a_idx   <= idx_c;
        a_write <= hwrite;
        a_lanes <= lanes_c;
      end
    end
  end

  // RAM is never reset; a write in flight during reset is dropped
  always_ff @(posedge hclk) begin
    if (hresetn && wr_c) begin
      for (int i = 0; i < 4; i++) begin
        if (a_lanes[i]) mem[a_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule
